// File: rtl/instr_fetch_unit.sv
// Instruction fetch: PC, variable-latency memory read, valid/ready handoff, JMP/JZ/HALT resolution.
// Define IFU_TIMEOUT_EN to enable the WAIT read timeout with retry and the sticky fetch_err flag.
module instr_fetch_unit #(
`ifdef IFU_TIMEOUT_EN
  parameter int TIMEOUT = 16,
`endif
  parameter int ADDR_W = 5,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [3:0] OP_JMP  = 4'b1000,
  parameter logic [3:0] OP_JZ   = 4'b1001,
  parameter logic [3:0] OP_HALT = 4'b1111
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [35:0]       mem_rdata,
  input  logic              mem_rvalid,
  output logic [35:0]       instruction,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              z,
  output logic              halted,
  output logic              fetch_err
);

  // state | meaning
  // FETCH | read strobe high for one cycle at mem_addr = PC
  // WAIT  | waiting for mem_rvalid
  // HOLD  | instruction presented until the decoder accepts it
  // HALT  | OP_HALT accepted, idle until reset
  typedef enum logic [1:0] {S_FETCH, S_WAIT, S_HOLD, S_HALT} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              rd_en_q, rd_en_d;
  logic [35:0]       instr_q, instr_d;
  logic              valid_q, valid_d;
  logic              halted_q, halted_d;

  logic [3:0]        op;
  logic [ADDR_W-1:0] tgt;
  logic [ADDR_W-1:0] pc_inc;

  assign op     = instr_q[3:0];
  assign tgt    = instr_q[ADDR_W+3:4];
  assign pc_inc = pc_q + 1'b1;

`ifdef IFU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
`endif

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    rd_en_d  = 1'b0;
    instr_d  = instr_q;
    valid_d  = valid_q;
    halted_d = halted_q;
`ifdef IFU_TIMEOUT_EN
    cnt_d    = cnt_q;
    err_d    = err_q;
`endif
    case (state_q)
      S_FETCH: begin
        // The strobe is raised on the edge entering FETCH; right after reset it is raised here instead.
        if (!rd_en_q) begin
          rd_en_d = 1'b1;
        end else begin
          state_d = S_WAIT;
`ifdef IFU_TIMEOUT_EN
          cnt_d   = CNT_W'(TIMEOUT - 1);
`endif
        end
      end
      S_WAIT: begin
        if (mem_rvalid) begin
          instr_d = mem_rdata;
          valid_d = 1'b1;
          state_d = S_HOLD;
        end
`ifdef IFU_TIMEOUT_EN
        else if (cnt_q == '0) begin
          err_d   = 1'b1;
          rd_en_d = 1'b1;
          state_d = S_FETCH;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
`endif
      end
      S_HOLD: begin
        if (instr_ready) begin
          valid_d = 1'b0;
          if (op == OP_HALT) begin
            halted_d = 1'b1;
            state_d  = S_HALT;
          end else begin
            rd_en_d = 1'b1;
            state_d = S_FETCH;
            if (op == OP_JMP || (op == OP_JZ && z)) pc_d = tgt;
            else                                    pc_d = pc_inc;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_FETCH;
      pc_q     <= RESET_PC;
      rd_en_q  <= 1'b0;
      instr_q  <= '0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
`ifdef IFU_TIMEOUT_EN
      cnt_q    <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      rd_en_q  <= rd_en_d;
      instr_q  <= instr_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
`ifdef IFU_TIMEOUT_EN
      cnt_q    <= cnt_d;
      err_q    <= err_d;
`endif
    end
  end

  assign mem_addr    = pc_q;
  assign mem_rd_en   = rd_en_q;
  assign instruction = instr_q;
  assign instr_valid = valid_q;
  assign halted      = halted_q;
`ifdef IFU_TIMEOUT_EN
  assign fetch_err   = err_q;
`else
  assign fetch_err   = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: behavioural memory, address/instruction scoreboard queues.
`define CHK(tag, obs, exp) begin n_checks++; assert ((obs) === (exp)) else begin n_errors++; $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp); end end

module tb_instr_fetch_unit;
  localparam logic [3:0] OP_JMP  = 4'b1000;
  localparam logic [3:0] OP_JZ   = 4'b1001;
  localparam logic [3:0] OP_HALT = 4'b1111;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  mem_addr;
  logic        mem_rd_en;
  logic [35:0] mem_rdata = '0;
  logic        mem_rvalid = 1'b0;
  logic [35:0] instruction;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        z = 1'b0;
  logic        halted;
  logic        fetch_err;

  int n_checks = 0;
  int n_errors = 0;

  logic [35:0] mem [32];
  int          lat = 1;
  bit          mute = 1'b0;
  int          pend = 0;
  logic [4:0]  paddr = '0;

  int          cyc = 0;
  int          last_rd = -1;
  bit          chk_period = 1'b0;
  logic        valid_prev = 1'b0;
  logic [4:0]  exp_addr[$];
  logic [35:0] exp_instr[$];

  instr_fetch_unit dut (
    .clk(clk), .rst_n(rst_n),
    .mem_addr(mem_addr), .mem_rd_en(mem_rd_en),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .instruction(instruction), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .z(z), .halted(halted), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Memory: answers a strobe seen at an edge after lat cycles with a one-cycle rvalid.
  always @(posedge clk) begin : mem_model
    logic       r;
    logic [4:0] a;
    r = mem_rd_en;
    a = mem_addr;
    #1;
    if (pend > 0) pend--;
    if (r) begin
      pend  = lat;
      paddr = a;
    end
    mem_rvalid = (pend == 1) && !mute;
    mem_rdata  = mem[paddr];
  end

  always @(negedge clk) begin : monitor
    logic [4:0]  ea;
    logic [35:0] ei;
    if (rst_n) begin
      if (mem_rd_en) begin
        n_checks++;
        assert (exp_addr.size() != 0) else begin
          n_errors++;
          $error("FAIL unexpected_fetch observed addr=%0d expected no fetch", mem_addr);
        end
        if (exp_addr.size() != 0) begin
          ea = exp_addr.pop_front();
          `CHK("fetch_addr", mem_addr, ea)
        end
        if (chk_period && last_rd >= 0) `CHK("fetch_period", cyc - last_rd, 3)
        last_rd = cyc;
      end
      if (instr_valid && !valid_prev) begin
        n_checks++;
        assert (exp_instr.size() != 0) else begin
          n_errors++;
          $error("FAIL unexpected_valid observed instr=%0h expected none", instruction);
        end
        if (exp_instr.size() != 0) begin
          ei = exp_instr.pop_front();
          `CHK("instr_word", instruction, ei)
        end
      end
    end
    valid_prev = instr_valid;
  end

  task automatic accept(input logic zz, input int stall, input logic [35:0] held);
    int n = 0;
    while (instr_valid !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    `CHK("valid_wait", instr_valid, 1'b1)
    z = zz;
    repeat (stall) begin
      @(negedge clk);
      `CHK("hold_instr", instruction, held)
      `CHK("hold_valid", instr_valid, 1'b1)
      `CHK("hold_no_rd", mem_rd_en, 1'b0)
    end
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    z = 1'b0;
    `CHK("valid_drop", instr_valid, 1'b0)
  endtask

  initial begin : watchdog
    #200000;
    $error("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin : stim
    int n;
    for (int i = 0; i < 32; i++) mem[i] = '0;
    mem[0]  = 36'h004;
    mem[1]  = 36'h002;
    mem[2]  = 36'h002;
    mem[3]  = {27'd0, 5'd9, OP_JZ};
    mem[9]  = {27'd0, 5'd3, OP_JMP};
    mem[4]  = {27'd0, 5'd20, OP_JMP};
    mem[20] = {27'd0, 5'd31, OP_JMP};
    mem[31] = 36'h005;

    repeat (3) @(posedge clk);
    #1;
    `CHK("rst_rd_en", mem_rd_en, 1'b0)
    `CHK("rst_addr", mem_addr, 5'd0)
    `CHK("rst_instr", instruction, 36'h0)
    `CHK("rst_valid", instr_valid, 1'b0)
    `CHK("rst_halted", halted, 1'b0)
    `CHK("rst_fetch_err", fetch_err, 1'b0)

`ifdef IFU_TIMEOUT_EN
    mute = 1'b1;
    exp_addr.push_back(5'd0);
`endif
    foreach (exp_addr[i]) ;
    exp_addr.push_back(5'd0);  exp_addr.push_back(5'd1);  exp_addr.push_back(5'd2);
    exp_addr.push_back(5'd3);  exp_addr.push_back(5'd9);  exp_addr.push_back(5'd3);
    exp_addr.push_back(5'd4);  exp_addr.push_back(5'd20); exp_addr.push_back(5'd31);
    exp_addr.push_back(5'd0);  exp_addr.push_back(5'd1);
    exp_instr.push_back(mem[0]);  exp_instr.push_back(mem[1]);  exp_instr.push_back(mem[2]);
    exp_instr.push_back(mem[3]);  exp_instr.push_back(mem[9]);  exp_instr.push_back(mem[3]);
    exp_instr.push_back(mem[4]);  exp_instr.push_back(mem[20]); exp_instr.push_back(mem[31]);
    exp_instr.push_back(mem[0]);

    @(negedge clk);
    rst_n = 1'b1;

`ifdef IFU_TIMEOUT_EN
    n = 0;
    while (mem_rd_en !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    `CHK("to_first_rd", mem_rd_en, 1'b1)
    repeat (16) @(negedge clk);
    `CHK("to_err_early", fetch_err, 1'b0)
    `CHK("to_no_rd_early", mem_rd_en, 1'b0)
    @(negedge clk);
    `CHK("to_err_set", fetch_err, 1'b1)
    `CHK("to_retry_rd", mem_rd_en, 1'b1)
    mute = 1'b0;
    lat  = 3;
`endif

    accept(1'b0, 0, 36'h0);            // addr 0
    #1;
    lat = 1;
    chk_period = 1'b1;
    accept(1'b0, 0, 36'h0);            // addr 1
    accept(1'b0, 0, 36'h0);            // addr 2
    accept(1'b1, 0, 36'h0);            // addr 3, JZ taken -> 9
    accept(1'b0, 0, 36'h0);            // addr 9, JMP -> 3
    chk_period = 1'b0;
    accept(1'b0, 5, mem[3]);           // addr 3, JZ not taken after backpressure -> 4
    accept(1'b0, 0, 36'h0);            // addr 4, JMP -> 20
    accept(1'b0, 0, 36'h0);            // addr 20, JMP -> 31
    accept(1'b0, 0, 36'h0);            // addr 31, plain -> wraps to 0
`ifdef IFU_TIMEOUT_EN
    `CHK("to_err_sticky", fetch_err, 1'b1)
`endif
    accept(1'b0, 0, 36'h0);            // addr 0 -> 1, read of 1 gets a slow memory
    lat = 10;

    repeat (3) @(negedge clk);
    `CHK("midwait_valid", instr_valid, 1'b0)
    `CHK("midwait_addr", mem_addr, 5'd1)
    rst_n = 1'b0;
    #1;
    `CHK("rst2_rd_en", mem_rd_en, 1'b0)
    `CHK("rst2_addr", mem_addr, 5'd0)
    `CHK("rst2_instr", instruction, 36'h0)
    `CHK("rst2_valid", instr_valid, 1'b0)
    `CHK("rst2_halted", halted, 1'b0)
    `CHK("rst2_fetch_err", fetch_err, 1'b0)
    exp_instr.delete();
    repeat (2) @(negedge clk);
    mem[1] = {32'd0, OP_HALT};
    lat = 1;
    exp_addr.push_back(5'd0);
    exp_addr.push_back(5'd1);
    exp_instr.push_back(mem[0]);
    exp_instr.push_back(mem[1]);
    rst_n = 1'b1;

    accept(1'b0, 0, 36'h0);            // addr 0
    accept(1'b0, 0, 36'h0);            // addr 1, HALT
    `CHK("halt_flag", halted, 1'b1)
    repeat (20) begin
      @(negedge clk);
      `CHK("halt_no_rd", mem_rd_en, 1'b0)
      `CHK("halt_valid", instr_valid, 1'b0)
      `CHK("halt_stays", halted, 1'b1)
    end
    `CHK("halt_fetch_err", fetch_err, 1'b0)
    `CHK("pending_fetches", exp_addr.size(), 0)
    `CHK("pending_instrs", exp_instr.size(), 0)

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
